// File: rtl/axi_rd_pkg.sv
// Shared types and helpers for the AXI read responder and its burst address generator.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_BURST
  } rsp_state_t;

  // A WRAP burst must span 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  burst_t            burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              wrap_illegal_o
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  always_comb begin
    bytes          = ADDR_W'(1) << size_i;
    wrap_mask      = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    wrap_ok        = wrap_len_legal(len_i);
    wrap_illegal_o = (burst_i == BURST_WRAP) && !wrap_ok;
    // INCR (and any unusable WRAP or reserved encoding) steps from the aligned address.
    next_addr_o    = (addr_i & ~(bytes - ADDR_W'(1))) + bytes;
    if (burst_i == BURST_FIXED) begin
      next_addr_o = addr_i;
    end else if ((burst_i == BURST_WRAP) && wrap_ok) begin
      next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + bytes) & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// Memory-side AXI read slave: one outstanding AR, bursts served from a preloadable word array.
module axi_read_responder
  import axi_rd_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int ADDR_W    = 64,
  parameter int LATENCY   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_axi_arvalid,
  input  logic [ADDR_W-1:0]            m_axi_araddr,
  input  logic [7:0]                   m_axi_arlen,
  input  logic [2:0]                   m_axi_arsize,
  input  logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arready,
  output logic                         m_axi_rvalid,
  output logic [63:0]                  m_axi_rdata,
  output logic                         m_axi_rlast,
  input  logic                         m_axi_rready,
  input  logic                         preload_we,
  input  logic [$clog2(MEM_WORDS)-1:0] preload_addr,
  input  logic [63:0]                  preload_data,
  output logic                         busy,
  output logic                         err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [63:0]       mem [MEM_WORDS];

  rsp_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt_q;
  logic [2:0]        size_q;
  burst_t            burst_q;
  logic [15:0]       lat_cnt_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              busy_q;
  logic              err_q;
  logic              wrap_illegal;
  logic              in_range;

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr_i         (addr_q),
    .len_i          (len_q),
    .size_i         (size_q),
    .burst_i        (burst_q),
    .next_addr_o    (next_addr),
    .wrap_illegal_o (wrap_illegal)
  );

  // Backdoor write lands at the edge, so a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (preload_we) begin
      mem[preload_addr] <= preload_data;
    end
  end

  assign in_range    = (addr_q[ADDR_W-1:3] < (ADDR_W-3)'(MEM_WORDS));
  assign m_axi_rdata = (rvalid_q && in_range) ? mem[addr_q[3 +: IDX_W]] : 64'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RSP_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_INCR;
      beat_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      case (state_q)
        RSP_IDLE: begin
          if (m_axi_arvalid) begin
            addr_q     <= m_axi_araddr;
            len_q      <= m_axi_arlen;
            size_q     <= m_axi_arsize;
            burst_q    <= burst_t'(m_axi_arburst);
            beat_cnt_q <= '0;
            lat_cnt_q  <= '0;
            arready_q  <= 1'b0;
            busy_q     <= 1'b1;
            if (LATENCY == 0) begin
              state_q  <= RSP_BURST;
              rvalid_q <= 1'b1;
              rlast_q  <= (m_axi_arlen == 8'd0);
            end else begin
              state_q  <= RSP_WAIT;
            end
          end
        end
        RSP_WAIT: begin
          if (lat_cnt_q == 16'(LATENCY - 1)) begin
            state_q  <= RSP_BURST;
            rvalid_q <= 1'b1;
            rlast_q  <= (len_q == 8'd0);
          end else begin
            lat_cnt_q <= lat_cnt_q + 16'd1;
          end
        end
        RSP_BURST: begin
          if (!in_range || wrap_illegal) begin
            err_q <= 1'b1;
          end
          if (m_axi_rready) begin
            if (rlast_q) begin
              state_q   <= RSP_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              // rlast is decided from the incremented count, so len=255 ends before the counter wraps.
              beat_cnt_q <= beat_cnt_q + 8'd1;
              addr_q     <= next_addr;
              rlast_q    <= ((beat_cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: state_q <= RSP_IDLE;
      endcase
    end
  end

  assign m_axi_arready = arready_q;
  assign m_axi_rvalid  = rvalid_q;
  assign m_axi_rlast   = rlast_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Randomized bench for axi_read_responder against a closed-form burst reference model.
module tb_axi_read_responder;
  import axi_rd_pkg::*;

  localparam int MEM_WORDS = 4096;
  localparam int ADDR_W    = 64;
  localparam int LATENCY   = 4;
  localparam int IDX_W     = $clog2(MEM_WORDS);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m_axi_arvalid = 1'b0;
  logic [ADDR_W-1:0] m_axi_araddr = '0;
  logic [7:0]        m_axi_arlen = '0;
  logic [2:0]        m_axi_arsize = '0;
  logic [1:0]        m_axi_arburst = '0;
  logic              m_axi_arready;
  logic              m_axi_rvalid;
  logic [63:0]       m_axi_rdata;
  logic              m_axi_rlast;
  logic              m_axi_rready = 1'b0;
  logic              preload_we = 1'b0;
  logic [IDX_W-1:0]  preload_addr = '0;
  logic [63:0]       preload_data = '0;
  logic              busy;
  logic              err;

  logic [63:0] mem_m [MEM_WORDS];
  bit          err_m = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  axi_read_responder #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arready (m_axi_arready),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rready  (m_axi_rready),
    .preload_we    (preload_we),
    .preload_addr  (preload_addr),
    .preload_data  (preload_data),
    .busy          (busy),
    .err           (err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Address of beat i, written directly as a function of the beat number.
  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [2:0] sz, input logic [1:0] bt, input int i);
    logic [63:0] b;
    logic [63:0] total;
    b     = 64'd1 << sz;
    total = (64'(len) + 64'd1) * b;
    if (bt == 2'b00) return a;
    if (bt == 2'b10 && (len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      return (a & ~(total - 64'd1)) | ((a + 64'(i) * b) & (total - 64'd1));
    if (i == 0) return a;
    return (a / b) * b + 64'(i) * b;
  endfunction

  function automatic logic [63:0] word_at(input logic [63:0] a);
    if ((a >> 3) >= 64'(MEM_WORDS)) return 64'd0;
    return mem_m[a[3 +: IDX_W]];
  endfunction

  task automatic preload(input int idx, input logic [63:0] d);
    preload_we   = 1'b1;
    preload_addr = IDX_W'(idx);
    preload_data = d;
    @(negedge clk);
    preload_we   = 1'b0;
    mem_m[idx]   = d;
  endtask

  task automatic send_ar(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
    check_val("arready_idle", 64'(m_axi_arready), 64'd1);
    m_axi_arvalid = 1'b1;
    m_axi_araddr  = a;
    m_axi_arlen   = len;
    m_axi_arsize  = sz;
    m_axi_arburst = bt;
    @(negedge clk);
    m_axi_arvalid = 1'b0;
  endtask

  task automatic wait_first(output int cyc);
    cyc = 0;
    while (!m_axi_rvalid && cyc < 200) begin
      check_val("wait_ctl", 64'({m_axi_arready, busy}), 64'b01);
      @(negedge clk);
      cyc++;
    end
  endtask

  // mode 0: rready always high; 1: pattern 1,0,0 repeating; 2: random.
  task automatic do_burst(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input int mode);
    int cyc;
    int beat;
    int guard;
    bit rr;
    for (int i = 0; i <= int'(len); i++)
      if ((beat_addr(a, len, sz, bt, i) >> 3) >= 64'(MEM_WORDS)) err_m = 1'b1;
    if (bt == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err_m = 1'b1;
    send_ar(a, len, sz, bt);
    wait_first(cyc);
    check_val("first_latency", 64'(cyc), 64'(LATENCY));
    beat  = 0;
    guard = 0;
    while (beat <= int'(len) && guard < 5000) begin
      check_val("rvalid", 64'(m_axi_rvalid), 64'd1);
      check_val("arready_busy", 64'(m_axi_arready), 64'd0);
      check_val("rdata", m_axi_rdata, word_at(beat_addr(a, len, sz, bt, beat)));
      check_val("rlast", 64'(m_axi_rlast), 64'(beat == int'(len)));
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (guard % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      m_axi_rready = rr;
      @(negedge clk);
      if (rr) beat++;
      guard++;
    end
    m_axi_rready = 1'b0;
    check_val("burst_beats", 64'(beat), 64'(int'(len) + 1));
    check_val("post_idle", 64'({m_axi_rvalid, m_axi_arready, busy, m_axi_rlast}), 64'b0100);
    check_val("err", 64'(err), 64'(err_m));
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          cyc;
    logic [1:0]  bt;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [63:0] a;
    logic [63:0] newv;

    repeat (3) @(negedge clk);
    check_val("rst_arready", 64'(m_axi_arready), 64'd1);
    check_val("rst_rvalid", 64'(m_axi_rvalid), 64'd0);
    check_val("rst_rlast", 64'(m_axi_rlast), 64'd0);
    check_val("rst_rdata", m_axi_rdata, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < MEM_WORDS; i++) preload(i, {$urandom, $urandom});
    for (int i = 0; i < 8; i++) preload(i, 64'h1000 + 64'(i));

    do_burst(64'h0, 8'd7, 3'd3, 2'b01, 0);
    do_burst(64'h28, 8'd3, 3'd3, 2'b10, 0);
    do_burst(64'h40, 8'd3, 3'd3, 2'b01, 1);
    do_burst(64'h10, 8'd3, 3'd3, 2'b00, 2);

    for (int k = 0; k < 40; k++) begin
      bt = 2'($urandom_range(0, 2));
      sz = 3'($urandom_range(0, 3));
      if (bt == 2'b10) len = 8'((2 << $urandom_range(0, 3)) - 1);
      else             len = 8'($urandom_range(0, 15));
      a = 64'($urandom_range(0, MEM_WORDS - 40)) * 64'd8 + 64'($urandom_range(0, 7));
      do_burst(a, len, sz, bt, 2);
    end

    do_burst(64'h0, 8'd255, 3'd3, 2'b01, 0);

    // Preload to the word being stalled on: old data this cycle, new data from the next.
    send_ar(64'h18, 8'd1, 3'd3, 2'b00);
    wait_first(cyc);
    check_val("pl_latency", 64'(cyc), 64'(LATENCY));
    check_val("pl_old", m_axi_rdata, mem_m[3]);
    newv         = {$urandom, $urandom};
    preload_we   = 1'b1;
    preload_addr = IDX_W'(3);
    preload_data = newv;
    @(negedge clk);
    preload_we   = 1'b0;
    mem_m[3]     = newv;
    check_val("pl_new", m_axi_rdata, newv);
    check_val("pl_rlast0", 64'(m_axi_rlast), 64'd0);
    m_axi_rready = 1'b1;
    @(negedge clk);
    check_val("pl_beat1", m_axi_rdata, newv);
    check_val("pl_rlast1", 64'(m_axi_rlast), 64'd1);
    @(negedge clk);
    m_axi_rready = 1'b0;
    check_val("pl_done", 64'({m_axi_rvalid, m_axi_arready}), 64'b01);

    do_burst(64'((MEM_WORDS - 1) * 8), 8'd1, 3'd3, 2'b01, 0);
    repeat (3) @(negedge clk);
    check_val("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of an 8-beat burst, with beat 3 on the bus.
    send_ar(64'h0, 8'd7, 3'd3, 2'b01);
    wait_first(cyc);
    m_axi_rready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mid_beat3", m_axi_rdata, mem_m[2]);
    m_axi_rready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("arst_rvalid", 64'(m_axi_rvalid), 64'd0);
    check_val("arst_arready", 64'(m_axi_arready), 64'd1);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_rdata", m_axi_rdata, 64'd0);
    check_val("arst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    err_m = 1'b0;
    @(negedge clk);
    check_val("after_rst_rvalid", 64'(m_axi_rvalid), 64'd0);
    do_burst(64'h30, 8'd0, 3'd3, 2'b01, 0);
    do_burst(64'h40, 8'd2, 3'd3, 2'b10, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
